// File: rtl/loader_pkg.sv
// Shared types and defaults for the UART program loader.
// Holds the loader state encoding, protocol byte defaults and the maximum-load helper.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_REPLY,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hAA;
    localparam logic [7:0] ACK_DEFAULT  = 8'h55;
    localparam logic [7:0] NAK_DEFAULT  = 8'hEE;

    // Largest frame length, in words, that fits the instruction memory.
    function automatic logic [63:0] max_len(input int unsigned addr_w);
        return 64'd1 << addr_w;
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Packs bytes MSB first into a WORD_W word and pulses word_done the cycle after the last byte.
// One cycle latency from final byte to word_done; no backpressure, clear drops a partial word.
module loader_word_packer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    localparam int NB    = WORD_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            word      <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (clear) begin
                idx <= '0;
            end else if (byte_valid) begin
                word <= WORD_W'({word, byte_data});
                if (idx == IDX_W'(NB - 1)) begin
                    idx       <= '0;
                    word_done <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: SYNC, big-endian word length, data words, checksum, then ACK/NAK reply.
// Writes each word one cycle after its last byte; the reply waits for tx_busy to drop.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int         WORD_W      = 32,
    parameter int         ADDR_W      = 10,
    parameter int         LEN_BYTES   = 2,
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
    parameter logic [7:0] ACK_BYTE    = ACK_DEFAULT,
    parameter logic [7:0] NAK_BYTE    = NAK_DEFAULT,
    parameter int         TIMEOUT_CYC = 5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_ferr,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam int LEN_W  = LEN_BYTES * 8;
    localparam int LCNT_W = $clog2(LEN_BYTES + 1);
    localparam int TMO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_t             state, nxt;
    logic [LEN_W-1:0]   len, new_len;
    logic [LCNT_W-1:0]  lcnt;
    logic [7:0]         csum;
    logic [TMO_W-1:0]   timer;
    logic               ok;
    logic [WORD_W-1:0]  word;
    logic               word_done;
    logic               byte_ok, byte_bad, tmo, in_frame, idle_like, sync_hit;
    logic               len_last, len_bad, last_word;

    assign byte_ok   = rx_valid & ~rx_ferr;
    assign byte_bad  = rx_valid & rx_ferr;
    assign in_frame  = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
    assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
    assign sync_hit  = byte_ok && (rx_data == SYNC_BYTE);
    // A byte in the same cycle as the timeout wins, hence the !rx_valid term.
    assign tmo       = (TIMEOUT_CYC != 0) && in_frame && !rx_valid && (timer == TMO_W'(TIMEOUT_CYC));
    assign new_len   = LEN_W'({len, rx_data});
    assign len_last  = (lcnt == LCNT_W'(LEN_BYTES - 1));
    assign len_bad   = (new_len == '0) || (64'(new_len) > max_len(ADDR_W));
    assign last_word = (64'(word_count) + 64'd1) == 64'(len);

    loader_word_packer #(.WORD_W(WORD_W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state != ST_DATA),
        .byte_data  (rx_data),
        .byte_valid (byte_ok && (state == ST_DATA)),
        .word       (word),
        .word_done  (word_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (sync_hit) nxt = ST_LEN;
            ST_LEN: begin
                if (byte_bad || tmo)          nxt = ST_REPLY;
                else if (byte_ok && len_last) nxt = len_bad ? ST_REPLY : ST_DATA;
            end
            ST_DATA: begin
                if (byte_bad || tmo)           nxt = ST_REPLY;
                else if (imem_we && last_word) nxt = ST_CSUM;
            end
            ST_CSUM:  if (rx_valid || tmo) nxt = ST_REPLY;
            ST_REPLY: if (!tx_busy) nxt = ok ? ST_DONE : ST_ERR;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_we    = (state == ST_DATA) && word_done;
        imem_addr  = word_count[ADDR_W-1:0];
        imem_wdata = word;
        tx_start   = (state == ST_REPLY) && !tx_busy;
        tx_data    = (state == ST_REPLY) ? (ok ? ACK_BYTE : NAK_BYTE) : 8'h00;
        done       = (state == ST_DONE);
        err        = (state == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len        <= '0;
            lcnt       <= '0;
            csum       <= '0;
            timer      <= '0;
            ok         <= 1'b0;
            word_count <= '0;
        end else begin
            // Success is only possible through a clean checksum byte.
            if (nxt == ST_REPLY && state != ST_REPLY)
                ok <= (state == ST_CSUM) && byte_ok && ((csum + rx_data) == 8'h00);
            if (idle_like && sync_hit) begin
                len        <= '0;
                lcnt       <= '0;
                csum       <= '0;
                timer      <= '0;
                word_count <= '0;
            end else if (in_frame) begin
                timer <= rx_valid ? '0 : timer + 1'b1;
                if (state == ST_LEN && byte_ok) begin
                    len  <= new_len;
                    lcnt <= lcnt + 1'b1;
                end
                if (state == ST_DATA && byte_ok) csum <= csum + rx_data;
                if (imem_we) word_count <= word_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized bench for uart_prog_loader with a frame-level reference model and per-cycle compare.
module tb_uart_prog_loader;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 4;
    localparam int TMO    = 100;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [WORD_W-1:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ferr = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    uart_prog_loader #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LEN_BYTES(2),
        .SYNC_BYTE(8'hAA), .ACK_BYTE(8'h55), .NAK_BYTE(8'hEE), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] seen_d[16];
    logic [7:0]  last_tx = 8'h00;
    int          tx_count = 0;
    bit          busy_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Per-cycle compare of writes and replies against the model's expectation queues.
    always @(negedge clk) begin
        wr_t w;
        if (!rst) begin
            if (imem_we) begin
                chk("write_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    w = exp_wr.pop_front();
                    chk("imem_addr", imem_addr, w.a);
                    chk("imem_wdata", imem_wdata, w.d);
                end
                seen_d[imem_addr] = imem_wdata;
            end
            if (tx_start) begin
                chk("tx_while_busy", tx_busy, 0);
                chk("reply_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) chk("tx_data", tx_data, exp_tx.pop_front());
                last_tx = tx_data;
                tx_count++;
            end
        end
    end

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_busy = busy_en ? ($urandom_range(0, 2) != 0) : 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit fe, input int gap);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        rx_ferr  = fe;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(posedge clk);
    endtask

    // Frame-level model: which words land, and whether the frame is accepted.
    task automatic model_frame(input bq_t fr, input int f, output bit okv, output int nw);
        int avail, len;
        logic [7:0] sum;
        wr_t w;
        avail = (f >= 0) ? f : fr.size();
        okv = 1'b0;
        nw = 0;
        sum = 8'h00;
        if (avail >= 3) begin
            len = {fr[1], fr[2]};
            if (len >= 1 && len <= 16) begin
                nw = (avail - 3) / 4;
                if (nw > len) nw = len;
                for (int i = 0; i < nw; i++) begin
                    w.a = ADDR_W'(i);
                    w.d = {fr[3+4*i], fr[4+4*i], fr[5+4*i], fr[6+4*i]};
                    exp_wr.push_back(w);
                end
                if (avail >= 4 + 4 * len) begin
                    for (int i = 3; i <= 3 + 4 * len; i++) sum = sum + fr[i];
                    okv = (sum == 8'h00);
                end
            end
        end
        exp_tx.push_back(okv ? 8'h55 : 8'hEE);
    endtask

    task automatic run_frame(input bq_t fr, input int f, input int gapmax, output int k);
        bit okv;
        int nw, tx0, last;
        tx0 = tx_count;
        model_frame(fr, f, okv, nw);
        last = (f >= 0) ? f : fr.size() - 1;
        for (int i = 0; i <= last; i++)
            send_byte(fr[i], i == f, (i == last) ? 0 : $urandom_range(1, gapmax));
        k = 0;
        while (tx_count == tx0 && k < 600) begin
            @(posedge clk);
            k++;
        end
        chk("reply_seen", tx_count - tx0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done", done, okv);
        chk("err", err, !okv);
        chk("word_count", word_count, nw);
        chk("writes_pending", exp_wr.size(), 0);
        chk("replies_pending", exp_tx.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t fr;
        int  k, len, mode, f, n;
        logic [7:0] sum;

        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {tx_data, tx_start, imem_we, imem_addr, imem_wdata, done, err, word_count}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Leading junk then a good two-word frame
        busy_en = 1'b1;
        send_byte(8'h3C, 1'b0, 2);
        send_byte(8'hFF, 1'b0, 2);
        fr = '{8'hAA, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h08, 8'hDC};
        run_frame(fr, -1, 3, k);
        chk("lit_word0", seen_d[0], 32'h01020304);
        chk("lit_word1", seen_d[1], 32'h05060708);
        chk("lit_ack", last_tx, 8'h55);
        chk("lit_wc", word_count, 2);

        // Bad checksum
        fr[11] = 8'hDD;
        run_frame(fr, -1, 3, k);
        chk("lit_nak_csum", last_tx, 8'hEE);
        chk("lit_err_csum", {done, err}, 2'b01);

        // Oversize length: NAK right after the second length byte
        busy_en = 1'b0;
        fr = '{8'hAA, 8'h00, 8'h11};
        run_frame(fr, -1, 3, k);
        chk("oversize_prompt", k <= 2, 1);
        chk("lit_nak_len", last_tx, 8'hEE);

        // Timeout after a partial word
        fr = '{8'hAA, 8'h00, 8'h01, 8'h01, 8'h02};
        run_frame(fr, -1, 3, k);
        chk("timeout_latency", (k >= 98 && k <= 106), 1);

        // Framing error on third data byte, then a clean frame clears err
        busy_en = 1'b1;
        fr = '{8'hAA, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h08, 8'hDC};
        run_frame(fr, 5, 3, k);
        chk("lit_err_ferr", err, 1);
        run_frame(fr, -1, 3, k);
        chk("lit_done_after_ferr", {done, err}, 2'b10);

        // Reset in the middle of the second word
        k = tx_count;
        fr = '{8'hAA, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        begin
            wr_t w;
            w.a = '0;
            w.d = 32'h11223344;
            exp_wr.push_back(w);
        end
        foreach (fr[i]) send_byte(fr[i], 1'b0, 3);
        @(negedge clk);
        chk("pre_reset_wc", word_count, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midframe_reset_outputs",
            {tx_data, tx_start, imem_we, imem_addr, imem_wdata, done, err, word_count}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        chk("reset_no_reply", tx_count - k, 0);
        chk("reset_writes", exp_wr.size(), 0);
        fr = '{8'hAA, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h08, 8'hDC};
        run_frame(fr, -1, 3, k);

        // Randomized frames
        for (int it = 0; it < 10; it++) begin
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                logic [7:0] jb;
                bit jf;
                jf = $urandom_range(0, 1);
                jb = 8'($urandom);
                if (jb == 8'hAA && !jf) jb = 8'h3C;
                send_byte(jb, jf, 2);
            end
            len  = $urandom_range(1, 16);
            mode = $urandom_range(0, 3);
            fr   = '{8'hAA, 8'(len >> 8), 8'(len)};
            sum  = 8'h00;
            for (int i = 0; i < 4 * len; i++) begin
                fr.push_back(8'($urandom));
                sum = sum + fr[fr.size()-1];
            end
            fr.push_back(8'(8'h00 - sum) ^ ((mode == 1) ? 8'h01 : 8'h00));
            f = -1;
            if (mode == 2) f = $urandom_range(1, fr.size() - 1);
            if (mode == 3) begin
                n = $urandom_range(1, fr.size() - 1);
                while (fr.size() > n) void'(fr.pop_back());
            end
            run_frame(fr, f, 4, k);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
